// File: rtl/axis_fifo_status_monitor.sv
// axis_fifo_status_monitor
//   Passive observer beside an AXI-Stream frame FIFO. It turns the FIFO's per-cycle
//   status into statistics that software can read: saturating good/bad/overflow frame
//   counters, peak marks for depth and committed depth, a fill alarm with hysteresis,
//   a sticky overflow flag and a one-cycle interrupt pulse. It never back-pressures
//   the FIFO. Every output is registered.
//
// Ports
//   clk_i             system clock, rising edge
//   reset_i           synchronous active-high reset, overrides everything
//   depth_i           FIFO current occupancy (DW bits)
//   depth_commit_i    FIFO committed whole-frame occupancy (DW bits)
//   overflow_i        pulse: frame dropped because the FIFO was full
//   bad_frame_i       pulse: frame dropped because of a tuser error
//   good_frame_i      pulse: frame committed
//   clear_stats_i     pulse: restart counters, peaks and sticky flag
//   good_count_o      committed-frame count (saturating)
//   bad_count_o       bad-frame count (saturating)
//   overflow_count_o  overflow-drop count (saturating)
//   peak_depth_o      maximum depth_i seen since reset or clear
//   peak_commit_o     maximum depth_commit_i seen since reset or clear
//   fill_alarm_o      hysteretic high-fill indication
//   overflow_sticky_o set by any overflow, held until clear or reset
//   irq_o             one-cycle pulse on fill_alarm or overflow_sticky rising
//
// Fill alarm FSM
//   state    | meaning
//   ST_IDLE  | fill level has not reached HIGH_MARK since it last fell to LOW_MARK
//   ST_ALARM | fill level reached HIGH_MARK and has not yet fallen to LOW_MARK

module axis_fifo_status_monitor #(
    parameter int DEPTH       = 256,
    parameter int COUNT_WIDTH = 32,
    parameter int HIGH_MARK   = 192,
    parameter int LOW_MARK    = 64,
    localparam int DW         = $clog2(DEPTH) + 1
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [DW-1:0]          depth_i,
    input  logic [DW-1:0]          depth_commit_i,
    input  logic                   overflow_i,
    input  logic                   bad_frame_i,
    input  logic                   good_frame_i,
    input  logic                   clear_stats_i,
    output logic [COUNT_WIDTH-1:0] good_count_o,
    output logic [COUNT_WIDTH-1:0] bad_count_o,
    output logic [COUNT_WIDTH-1:0] overflow_count_o,
    output logic [DW-1:0]          peak_depth_o,
    output logic [DW-1:0]          peak_commit_o,
    output logic                   fill_alarm_o,
    output logic                   overflow_sticky_o,
    output logic                   irq_o
);

    if (LOW_MARK >= HIGH_MARK) begin : g_bad_marks
        $error("axis_fifo_status_monitor: LOW_MARK must be below HIGH_MARK");
    end
    if (HIGH_MARK > DEPTH) begin : g_bad_high
        $error("axis_fifo_status_monitor: HIGH_MARK must not exceed DEPTH");
    end
    if (COUNT_WIDTH < 1) begin : g_bad_width
        $error("axis_fifo_status_monitor: COUNT_WIDTH must be at least 1");
    end

    localparam logic [DW-1:0] HIGH_W = DW'(HIGH_MARK);
    localparam logic [DW-1:0] LOW_W  = DW'(LOW_MARK);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ALARM = 1'b1
    } state_e;

    state_e state_q, state_d;

    logic [COUNT_WIDTH-1:0] good_q, good_d;
    logic [COUNT_WIDTH-1:0] bad_q, bad_d;
    logic [COUNT_WIDTH-1:0] ovf_q, ovf_d;
    logic [DW-1:0]          peak_depth_q, peak_depth_d;
    logic [DW-1:0]          peak_commit_q, peak_commit_d;
    logic                   sticky_q, sticky_d;
    logic                   irq_q, irq_d;

    // A clear restarts the counter from the event seen in the same cycle,
    // so a pulse coincident with clear_stats is never lost.
    function automatic logic [COUNT_WIDTH-1:0] next_count(
        input logic [COUNT_WIDTH-1:0] cur,
        input logic                   ev,
        input logic                   clr
    );
        if (clr) begin
            return ev ? COUNT_WIDTH'(1) : '0;
        end else if (ev && (cur != '1)) begin
            return cur + COUNT_WIDTH'(1);
        end else begin
            return cur;
        end
    endfunction

    // FSM: state register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (depth_i >= HIGH_W) state_d = ST_ALARM;
            ST_ALARM: if (depth_i <= LOW_W)  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM: output logic
    always_comb begin
        fill_alarm_o = (state_q == ST_ALARM);
    end

    // Statistics next-state
    always_comb begin
        good_d = next_count(good_q, good_frame_i, clear_stats_i);
        bad_d  = next_count(bad_q,  bad_frame_i,  clear_stats_i);
        ovf_d  = next_count(ovf_q,  overflow_i,   clear_stats_i);

        if (clear_stats_i || (depth_i > peak_depth_q)) begin
            peak_depth_d = depth_i;
        end else begin
            peak_depth_d = peak_depth_q;
        end

        if (clear_stats_i || (depth_commit_i > peak_commit_q)) begin
            peak_commit_d = depth_commit_i;
        end else begin
            peak_commit_d = peak_commit_q;
        end

        sticky_d = clear_stats_i ? overflow_i : (sticky_q | overflow_i);

        // During a clear the flag is considered to restart from 0, so an
        // overflow in that cycle counts as a fresh rise and raises irq.
        irq_d = ((state_q == ST_IDLE) && (state_d == ST_ALARM)) ||
                (overflow_i && (clear_stats_i || !sticky_q));
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            good_q        <= '0;
            bad_q         <= '0;
            ovf_q         <= '0;
            peak_depth_q  <= '0;
            peak_commit_q <= '0;
            sticky_q      <= 1'b0;
            irq_q         <= 1'b0;
        end else begin
            good_q        <= good_d;
            bad_q         <= bad_d;
            ovf_q         <= ovf_d;
            peak_depth_q  <= peak_depth_d;
            peak_commit_q <= peak_commit_d;
            sticky_q      <= sticky_d;
            irq_q         <= irq_d;
        end
    end

    assign good_count_o      = good_q;
    assign bad_count_o       = bad_q;
    assign overflow_count_o  = ovf_q;
    assign peak_depth_o      = peak_depth_q;
    assign peak_commit_o     = peak_commit_q;
    assign overflow_sticky_o = sticky_q;
    assign irq_o             = irq_q;

endmodule

// File: tb/tb_axis_fifo_status_monitor.sv
// Testbench for axis_fifo_status_monitor (DEPTH=16, COUNT_WIDTH=4, HIGH_MARK=12, LOW_MARK=4).
// Each step drives one cycle of inputs, queues the expected outputs and compares
// them just after the sampling edge.

module tb_axis_fifo_status_monitor;

    localparam int DEPTH = 16;
    localparam int CW    = 4;
    localparam int HM    = 12;
    localparam int LM    = 4;
    localparam int DW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] depth;
    logic [DW-1:0] depth_commit;
    logic          overflow;
    logic          bad_frame;
    logic          good_frame;
    logic          clear_stats;
    logic [CW-1:0] good_count;
    logic [CW-1:0] bad_count;
    logic [CW-1:0] overflow_count;
    logic [DW-1:0] peak_depth;
    logic [DW-1:0] peak_commit;
    logic          fill_alarm;
    logic          overflow_sticky;
    logic          irq;

    always #5 clk = ~clk;

    axis_fifo_status_monitor #(
        .DEPTH      (DEPTH),
        .COUNT_WIDTH(CW),
        .HIGH_MARK  (HM),
        .LOW_MARK   (LM)
    ) dut (
        .clk_i            (clk),
        .reset_i          (reset),
        .depth_i          (depth),
        .depth_commit_i   (depth_commit),
        .overflow_i       (overflow),
        .bad_frame_i      (bad_frame),
        .good_frame_i     (good_frame),
        .clear_stats_i    (clear_stats),
        .good_count_o     (good_count),
        .bad_count_o      (bad_count),
        .overflow_count_o (overflow_count),
        .peak_depth_o     (peak_depth),
        .peak_commit_o    (peak_commit),
        .fill_alarm_o     (fill_alarm),
        .overflow_sticky_o(overflow_sticky),
        .irq_o            (irq)
    );

    typedef struct {
        logic          rst;
        logic [DW-1:0] d;
        logic [DW-1:0] dc;
        logic          ov;
        logic          bad;
        logic          good;
        logic          clr;
        logic [CW-1:0] eg;
        logic [CW-1:0] eb;
        logic [CW-1:0] eo;
        logic [DW-1:0] epd;
        logic [DW-1:0] epc;
        logic          ea;
        logic          es;
        logic          ei;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic vec_t mk(
        input logic rst, input int d, input int dc,
        input logic ov, input logic bad, input logic good, input logic clr,
        input int eg, input int eb, input int eo, input int epd, input int epc,
        input logic ea, input logic es, input logic ei
    );
        vec_t t;
        t.rst  = rst;
        t.d    = DW'(d);
        t.dc   = DW'(dc);
        t.ov   = ov;
        t.bad  = bad;
        t.good = good;
        t.clr  = clr;
        t.eg   = CW'(eg);
        t.eb   = CW'(eb);
        t.eo   = CW'(eo);
        t.epd  = DW'(epd);
        t.epc  = DW'(epc);
        t.ea   = ea;
        t.es   = es;
        t.ei   = ei;
        return t;
    endfunction

    task automatic chk(input string nm, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s step %0d: got %0d expected %0d", nm, idx, act, exp);
        end
    endtask

    task automatic step(input vec_t v, input int idx);
        vec_t e;
        @(negedge clk);
        reset        = v.rst;
        depth        = v.d;
        depth_commit = v.dc;
        overflow     = v.ov;
        bad_frame    = v.bad;
        good_frame   = v.good;
        clear_stats  = v.clr;
        sb.push_back(v);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard step %0d: got empty queue expected one entry", idx);
        end else begin
            e = sb.pop_front();
            chk("good_count",      idx, int'(good_count),      int'(e.eg));
            chk("bad_count",       idx, int'(bad_count),       int'(e.eb));
            chk("overflow_count",  idx, int'(overflow_count),  int'(e.eo));
            chk("peak_depth",      idx, int'(peak_depth),      int'(e.epd));
            chk("peak_commit",     idx, int'(peak_commit),     int'(e.epc));
            chk("fill_alarm",      idx, int'(fill_alarm),      int'(e.ea));
            chk("overflow_sticky", idx, int'(overflow_sticky), int'(e.es));
            chk("irq",             idx, int'(irq),             int'(e.ei));
        end
    endtask

    initial begin
        reset        = 1'b1;
        depth        = '0;
        depth_commit = '0;
        overflow     = 1'b0;
        bad_frame    = 1'b0;
        good_frame   = 1'b0;
        clear_stats  = 1'b0;

        //           rst d   dc  ov bad gd clr  g  b  o  pd  pc  a  s  irq
        vecs.push_back(mk(1, 0,  0,  0, 0, 0, 0,   0, 0, 0, 0,  0,  0, 0, 0)); // reset state
        // frame counting, one irq one cycle after the overflow pulse
        vecs.push_back(mk(0, 0,  0,  0, 0, 1, 0,   1, 0, 0, 0,  0,  0, 0, 0));
        vecs.push_back(mk(0, 0,  0,  0, 0, 1, 0,   2, 0, 0, 0,  0,  0, 0, 0));
        vecs.push_back(mk(0, 0,  0,  0, 0, 1, 0,   3, 0, 0, 0,  0,  0, 0, 0));
        vecs.push_back(mk(0, 0,  0,  0, 1, 0, 0,   3, 1, 0, 0,  0,  0, 0, 0));
        vecs.push_back(mk(0, 0,  0,  0, 1, 0, 0,   3, 2, 0, 0,  0,  0, 0, 0));
        vecs.push_back(mk(0, 0,  0,  1, 0, 0, 0,   3, 2, 1, 0,  0,  0, 1, 1));
        vecs.push_back(mk(0, 0,  0,  0, 0, 0, 0,   3, 2, 1, 0,  0,  0, 1, 0));
        // depth ramp 13 -> 8 -> 12 -> 4 -> 5
        vecs.push_back(mk(0, 13, 10, 0, 0, 0, 0,   3, 2, 1, 13, 10, 1, 1, 1));
        vecs.push_back(mk(0, 8,  8,  0, 0, 0, 0,   3, 2, 1, 13, 10, 1, 1, 0));
        vecs.push_back(mk(0, 12, 8,  0, 0, 0, 0,   3, 2, 1, 13, 10, 1, 1, 0));
        vecs.push_back(mk(0, 4,  8,  0, 0, 0, 0,   3, 2, 1, 13, 10, 0, 1, 0));
        vecs.push_back(mk(0, 5,  8,  0, 0, 0, 0,   3, 2, 1, 13, 10, 0, 1, 0));
        // clear with coincident good frame while the alarm is up
        vecs.push_back(mk(0, 14, 2,  0, 0, 0, 0,   3, 2, 1, 14, 10, 1, 1, 1));
        vecs.push_back(mk(0, 7,  3,  0, 0, 1, 1,   1, 0, 0, 7,  3,  1, 0, 0));
        vecs.push_back(mk(0, 7,  0,  0, 0, 0, 0,   1, 0, 0, 7,  3,  1, 0, 0));
        // overflow and alarm rise together -> single irq
        vecs.push_back(mk(0, 3,  0,  0, 0, 0, 0,   1, 0, 0, 7,  3,  0, 0, 0));
        vecs.push_back(mk(0, 12, 0,  1, 0, 0, 0,   1, 0, 1, 12, 3,  1, 1, 1));
        vecs.push_back(mk(0, 12, 0,  0, 0, 0, 0,   1, 0, 1, 12, 3,  1, 1, 0));
        // clear with overflow: sticky reloads to 1 and irq fires
        vecs.push_back(mk(0, 0,  0,  1, 1, 0, 1,   0, 1, 1, 0,  0,  0, 1, 1));
        vecs.push_back(mk(0, 0,  0,  0, 0, 0, 0,   0, 1, 1, 0,  0,  0, 1, 0));
        // full-width unsigned peak (MSB of depth set)
        vecs.push_back(mk(0, 16, 16, 0, 0, 0, 0,   0, 1, 1, 16, 16, 1, 1, 1));
        vecs.push_back(mk(0, 15, 1,  0, 0, 0, 0,   0, 1, 1, 16, 16, 1, 1, 0));
        // simultaneous good/bad/overflow
        vecs.push_back(mk(0, 15, 1,  1, 1, 1, 0,   1, 2, 2, 16, 16, 1, 1, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i], i);
        end

        // good_frame held high: counter saturates at 15 and never wraps
        for (int i = 1; i <= 20; i++) begin
            step(mk(0, 15, 1, 0, 0, 1, (i == 1), (i < 15) ? i : 15, 0, 0, 15, 1, 1, 0, 0), 100 + i);
        end

        // reset with alarm up, counters nonzero and clear_stats high
        step(mk(1, 15, 1, 1, 1, 1, 1,   0, 0, 0, 0,  0, 0, 0, 0), 200);
        step(mk(0, 13, 0, 0, 0, 0, 0,   0, 0, 0, 13, 0, 1, 0, 1), 201);
        step(mk(0, 13, 0, 0, 0, 0, 0,   0, 0, 0, 13, 0, 1, 0, 0), 202);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
